// File: rtl/pc_redirect_sequencer.sv
// Fetch-stage sequencer for interrupt entry, CALL and RET/RTI redirects, including 16-bit stack push/pop.
// Optional nested interrupts are enabled by defining INTR_NEST_EN.
module pc_redirect_sequencer #(
  parameter int PC_W         = 32,
  parameter int HALF_W       = 16,
  parameter int DRAIN_CYCLES = 2,
  parameter int MAX_NEST     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              intr_req,
  input  logic              call_dec,
  input  logic              ret_dec,
  input  logic              rti_dec,
  input  logic [PC_W-1:0]   ret_pc,
  input  logic              hazard_stall,
  output logic              stk_req,
  output logic              stk_we,
  output logic [HALF_W-1:0] stk_wdata,
  input  logic              stk_ack,
  input  logic [HALF_W-1:0] stk_rdata,
  output logic              take_intr,
  output logic              take_call,
  output logic              pop_signal,
  output logic [PC_W-1:0]   popped_pc,
  output logic              stall_jump,
  output logic              in_isr
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_PUSH_HI, S_PUSH_LO, S_POP_LO, S_POP_HI, S_REDIRECT
  } state_t;

  typedef enum logic [1:0] {K_CALL, K_INT, K_RET, K_RTI} kind_t;

  state_t            r_state;
  kind_t             r_kind;
  logic [DW-1:0]     r_cnt;
  logic [PC_W-1:0]   r_pc;
  logic              r_stk_req;
  logic              r_stk_we;
  logic [HALF_W-1:0] r_stk_wdata;
  logic              r_take_intr;
  logic              r_take_call;
  logic              r_pop_signal;
  logic [PC_W-1:0]   r_popped_pc;
  logic              r_stall_jump;
  logic              r_in_isr;
  logic              w_ack;
  logic              w_intr_ok;

  // An ack is only meaningful while a request is outstanding.
  assign w_ack = stk_ack & r_stk_req;

`ifdef INTR_NEST_EN
  localparam int NW = $clog2(MAX_NEST + 1);
  logic [NW-1:0] r_nest;
  assign w_intr_ok = (r_nest < NW'(MAX_NEST));
`else
  assign w_intr_ok = !r_in_isr && (MAX_NEST > 0);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_kind       <= K_CALL;
      r_cnt        <= '0;
      r_pc         <= '0;
      r_stk_req    <= 1'b0;
      r_stk_we     <= 1'b0;
      r_stk_wdata  <= '0;
      r_take_intr  <= 1'b0;
      r_take_call  <= 1'b0;
      r_pop_signal <= 1'b0;
      r_popped_pc  <= '0;
      r_stall_jump <= 1'b0;
      r_in_isr     <= 1'b0;
`ifdef INTR_NEST_EN
      r_nest       <= '0;
`endif
    end else begin
      r_take_intr  <= 1'b0;
      r_take_call  <= 1'b0;
      r_pop_signal <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!hazard_stall) begin
            if (rti_dec || ret_dec) begin
              r_kind       <= rti_dec ? K_RTI : K_RET;
              r_state      <= S_POP_LO;
              r_stk_req    <= 1'b1;
              r_stk_we     <= 1'b0;
              r_stall_jump <= 1'b1;
            end else if (call_dec) begin
              r_kind       <= K_CALL;
              r_pc         <= ret_pc;
              r_state      <= S_PUSH_HI;
              r_stk_req    <= 1'b1;
              r_stk_we     <= 1'b1;
              r_stk_wdata  <= ret_pc[PC_W-1:HALF_W];
              r_stall_jump <= 1'b1;
            end else if (intr_req && w_intr_ok) begin
              r_kind       <= K_INT;
              r_pc         <= ret_pc;
              r_state      <= S_DRAIN;
              r_cnt        <= '0;
              r_stall_jump <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (r_cnt == DW'(DRAIN_CYCLES - 1)) begin
            r_state     <= S_PUSH_HI;
            r_stk_req   <= 1'b1;
            r_stk_we    <= 1'b1;
            r_stk_wdata <= r_pc[PC_W-1:HALF_W];
          end else begin
            r_cnt <= r_cnt + DW'(1);
          end
        end
        S_PUSH_HI: begin
          if (w_ack) begin
            r_state     <= S_PUSH_LO;
            r_stk_wdata <= r_pc[HALF_W-1:0];
          end
        end
        S_PUSH_LO: begin
          if (w_ack) begin
            r_state      <= S_REDIRECT;
            r_stk_req    <= 1'b0;
            r_stk_we     <= 1'b0;
            r_stall_jump <= 1'b0;
          end
        end
        S_POP_LO: begin
          if (w_ack) begin
            r_state            <= S_POP_HI;
            r_pc[HALF_W-1:0]   <= stk_rdata;
          end
        end
        S_POP_HI: begin
          if (w_ack) begin
            r_state              <= S_REDIRECT;
            r_pc[PC_W-1:HALF_W]  <= stk_rdata;
            r_stk_req            <= 1'b0;
            r_stall_jump         <= 1'b0;
          end
        end
        S_REDIRECT: begin
          r_state <= S_IDLE;
          case (r_kind)
            K_CALL: r_take_call <= 1'b1;
            K_INT: begin
              r_take_intr <= 1'b1;
              r_in_isr    <= 1'b1;
`ifdef INTR_NEST_EN
              r_nest      <= r_nest + NW'(1);
`endif
            end
            K_RET: begin
              r_pop_signal <= 1'b1;
              r_popped_pc  <= r_pc;
            end
            K_RTI: begin
              r_pop_signal <= 1'b1;
              r_popped_pc  <= r_pc;
`ifdef INTR_NEST_EN
              if (r_nest != '0) r_nest <= r_nest - NW'(1);
              r_in_isr <= (r_nest > NW'(1));
`else
              r_in_isr <= 1'b0;
`endif
            end
            default: r_take_call <= 1'b0;
          endcase
        end
        default: begin
          r_state      <= S_IDLE;
          r_stk_req    <= 1'b0;
          r_stall_jump <= 1'b0;
        end
      endcase
    end
  end

  assign stk_req    = r_stk_req;
  assign stk_we     = r_stk_we;
  assign stk_wdata  = r_stk_wdata;
  assign take_intr  = r_take_intr;
  assign take_call  = r_take_call;
  assign pop_signal = r_pop_signal;
  assign popped_pc  = r_popped_pc;
  assign stall_jump = r_stall_jump;
  assign in_isr     = r_in_isr;

endmodule

// File: tb/tb_pc_redirect_sequencer.sv
// Bench for pc_redirect_sequencer: stack responder model, pulse scoreboard, vector table and corner sequences.
module tb_pc_redirect_sequencer;

  localparam int OP_CALL = 0, OP_INT = 1, OP_RET = 2, OP_RTI = 3;
`ifdef INTR_NEST_EN
  localparam int NEST_LVL = 4;
`else
  localparam int NEST_LVL = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        intr_req = 1'b0, call_dec = 1'b0, ret_dec = 1'b0, rti_dec = 1'b0;
  logic [31:0] ret_pc = '0;
  logic        hazard_stall = 1'b0;
  logic        stk_req, stk_we;
  logic [15:0] stk_wdata;
  logic        stk_ack = 1'b0;
  logic [15:0] stk_rdata = '0;
  logic        take_intr, take_call, pop_signal;
  logic [31:0] popped_pc;
  logic        stall_jump, in_isr;

  pc_redirect_sequencer #(.PC_W(32), .HALF_W(16), .DRAIN_CYCLES(2), .MAX_NEST(4)) dut (
    .clk(clk), .reset(reset), .intr_req(intr_req), .call_dec(call_dec), .ret_dec(ret_dec),
    .rti_dec(rti_dec), .ret_pc(ret_pc), .hazard_stall(hazard_stall), .stk_req(stk_req),
    .stk_we(stk_we), .stk_wdata(stk_wdata), .stk_ack(stk_ack), .stk_rdata(stk_rdata),
    .take_intr(take_intr), .take_call(take_call), .pop_signal(pop_signal),
    .popped_pc(popped_pc), .stall_jump(stall_jump), .in_isr(in_isr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  pulse;  // {take_intr, take_call, pop_signal}
    int          cyc;
    logic [31:0] pc;
  } exp_t;
  exp_t        exp_q[$];
  logic [15:0] exp_push[$];
  logic [15:0] tb_stk[$];
  logic        req_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stack responder: acks one cycle after seeing a request, one-cycle ack pulses.
  always @(negedge clk) begin
    if (!reset) begin
      stk_ack  = 1'b0;
      req_seen = 1'b0;
    end else if (stk_ack) begin
      stk_ack  = 1'b0;
      req_seen = stk_req;
    end else if (stk_req) begin
      if (req_seen) begin
        stk_ack  = 1'b1;
        req_seen = 1'b0;
        if (stk_we) begin
          if (exp_push.size() == 0) begin
            tests++; fails++;
            $display("FAIL push_unexpected: got 0x%0h, expected no push", stk_wdata);
          end else begin
            check("push_data", 32'(stk_wdata), 32'(exp_push.pop_front()));
          end
        end else begin
          stk_rdata = (tb_stk.size() != 0) ? tb_stk.pop_back() : 16'h0;
        end
      end else begin
        req_seen = 1'b1;
      end
    end else begin
      req_seen = 1'b0;
    end
  end

  // Pulse monitor: pops the scoreboard whenever a redirect pulse appears.
  always @(negedge clk) begin
    if (reset && (take_intr || take_call || pop_signal)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {29'd0, take_intr, take_call, pop_signal}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_kind", {29'd0, take_intr, take_call, pop_signal}, {29'd0, e.pulse});
        check("pulse_cycle", 32'(cyc), 32'(e.cyc));
        check("stall_at_pulse", {31'd0, stall_jump}, 32'd0);
        if (e.pulse == 3'b001) check("popped_pc", popped_pc, e.pc);
      end
    end
  end

  task automatic wait_drain(input string name);
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      check({name, "_timeout"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(negedge clk);
    check({name, "_push_left"}, 32'(exp_push.size()), 32'd0);
    exp_push.delete();
  endtask

  task automatic run_op(input int op, input logic [31:0] pc, input logic [15:0] hi,
                        input logic [15:0] lo, input int lat, input logic exp_isr);
    exp_t e;
    @(negedge clk);
    ret_pc = pc;
    e.cyc = cyc + 1 + lat;
    e.pc  = {hi, lo};
    case (op)
      OP_CALL: begin call_dec = 1'b1; e.pulse = 3'b010; end
      OP_INT:  begin intr_req = 1'b1; e.pulse = 3'b100; end
      OP_RET:  begin ret_dec  = 1'b1; e.pulse = 3'b001; end
      default: begin rti_dec  = 1'b1; e.pulse = 3'b001; end
    endcase
    if (op == OP_CALL || op == OP_INT) begin
      exp_push.push_back(pc[31:16]);
      exp_push.push_back(pc[15:0]);
    end else begin
      tb_stk.push_back(hi);
      tb_stk.push_back(lo);
    end
    exp_q.push_back(e);
    @(negedge clk);
    call_dec = 1'b0; ret_dec = 1'b0; rti_dec = 1'b0; intr_req = 1'b0;
    wait_drain("op");
    check("in_isr_after_op", {31'd0, in_isr}, {31'd0, exp_isr});
  endtask

  typedef struct {
    int          op;
    logic [31:0] pc;
    logic [15:0] hi, lo;
    int          lat;
    logic        isr;
  } vec_t;
  vec_t vec[6];

  initial begin
    vec[0] = '{OP_INT,  32'h0001_0234, 16'h0001, 16'h0234, 7, 1'b1};
    vec[1] = '{OP_RET,  32'h0,         16'h0009, 16'h5678, 5, 1'b1};
    vec[2] = '{OP_RTI,  32'h0,         16'hDEAD, 16'hBEEF, 5, 1'b0};
    vec[3] = '{OP_CALL, 32'h0000_0040, 16'h0000, 16'h0040, 5, 1'b0};
    vec[4] = '{OP_CALL, 32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF, 5, 1'b0};
    vec[5] = '{OP_RET,  32'h0,         16'h0000, 16'h0000, 5, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_stk_req", {31'd0, stk_req}, 32'd0);
    check("rst_stk_we", {31'd0, stk_we}, 32'd0);
    check("rst_stk_wdata", 32'(stk_wdata), 32'd0);
    check("rst_pulses", {29'd0, take_intr, take_call, pop_signal}, 32'd0);
    check("rst_popped_pc", popped_pc, 32'd0);
    check("rst_stall", {31'd0, stall_jump}, 32'd0);
    check("rst_in_isr", {31'd0, in_isr}, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_op(vec[i].op, vec[i].pc, vec[i].hi, vec[i].lo, vec[i].lat, vec[i].isr);

    // CALL and interrupt together: CALL first, interrupt stays pending and follows.
    begin
      exp_t e;
      @(negedge clk);
      ret_pc = 32'h40; call_dec = 1'b1; intr_req = 1'b1;
      repeat (2) begin exp_push.push_back(16'h0000); exp_push.push_back(16'h0040); end
      e.pc = 32'h0;
      e.pulse = 3'b010; e.cyc = cyc + 6;  exp_q.push_back(e);
      e.pulse = 3'b100; e.cyc = cyc + 14; exp_q.push_back(e);
      @(negedge clk);
      call_dec = 1'b0;
      repeat (6) @(negedge clk);
      intr_req = 1'b0;
      wait_drain("call_intr");
      check("call_intr_in_isr", {31'd0, in_isr}, 32'd1);
    end

    // Interrupts beyond the allowed depth are ignored.
    for (int n = 1; n < NEST_LVL; n++) run_op(OP_INT, 32'h0000_1000 + n, 16'h0000, 16'h1000 + 16'(n), 7, 1'b1);
    @(negedge clk);
    intr_req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("blocked_stk_req", {31'd0, stk_req}, 32'd0);
      check("blocked_stall", {31'd0, stall_jump}, 32'd0);
    end
    intr_req = 1'b0;
    for (int n = NEST_LVL; n >= 1; n--) run_op(OP_RTI, 32'h0, 16'h00AB, 16'(n), 5, n > 1);

    // hazard_stall blocks leaving IDLE; the CALL pulse is lost.
    @(negedge clk);
    hazard_stall = 1'b1; call_dec = 1'b1; ret_pc = 32'h7777_8888;
    @(negedge clk);
    call_dec = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("hazard_stk_req", {31'd0, stk_req}, 32'd0);
      check("hazard_stall_jump", {31'd0, stall_jump}, 32'd0);
      @(negedge clk);
    end
    hazard_stall = 1'b0;
    repeat (6) @(negedge clk);
    check("hazard_no_pulse", 32'(exp_q.size()), 32'd0);

    // Reset during PUSH_LO of a CALL taken inside an ISR.
    run_op(OP_INT, 32'h0002_0000, 16'h0002, 16'h0000, 7, 1'b1);
    @(negedge clk);
    ret_pc = 32'h1234_5678; call_dec = 1'b1;
    exp_push.push_back(16'h1234);
    @(negedge clk);
    call_dec = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_push_lo_wdata", 32'(stk_wdata), 32'h5678);
    check("mid_push_lo_req", {31'd0, stk_req}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_stk_req", {31'd0, stk_req}, 32'd0);
    check("rst_mid_pulses", {29'd0, take_intr, take_call, pop_signal}, 32'd0);
    check("rst_mid_in_isr", {31'd0, in_isr}, 32'd0);
    check("rst_mid_stall", {31'd0, stall_jump}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    check("rst_mid_idle_req", {31'd0, stk_req}, 32'd0);
    check("rst_mid_push_left", 32'(exp_push.size()), 32'd0);
    tb_stk.delete();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
